// File: rtl/frame_packer.sv
// frame_packer: snapshots a frame of counter words and streams it to a UART
// transmitter as header (A5 5A SEQ DROPS), payload bytes and a checksum byte.
module frame_packer #(
   parameter int NUM_WORDS  = 4,
   parameter int RESOLUTION = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_WORDS*RESOLUTION-1:0] frame_data,
   input  logic                            frame_strobe,
   output logic [7:0]                      tx_byte,
   output logic                            tx_valid,
   input  logic                            tx_ready,
   output logic                            busy,
   output logic                            overflow
);

   localparam int DATA_W    = NUM_WORDS * RESOLUTION;
   localparam int NUM_BYTES = DATA_W / 8;
   localparam int IDX_W     = (NUM_BYTES > 4) ? $clog2(NUM_BYTES) : 2;

   localparam logic [IDX_W-1:0] IDX_SEQ  = IDX_W'(2);
   localparam logic [IDX_W-1:0] LAST_HDR = IDX_W'(3);
   localparam logic [IDX_W-1:0] LAST_PAY = IDX_W'(NUM_BYTES - 1);

   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CHECK} state_t;

   state_t            state, state_next;
   logic [IDX_W-1:0]  idx, idx_next;
   logic [DATA_W-1:0] snapshot;
   logic [7:0]        seq;        // frame counter, bumps when CHECK transfers
   logic [7:0]        drop_cnt;   // frames dropped since the last latch
   logic [7:0]        drops;      // drop count carried in the current header
   logic [7:0]        csum;       // running sum of SEQ, DROPS and payload
   logic              xfer;       // a byte moves this cycle
   logic              latch;      // capture frame_data and start a frame
   logic              drop;       // strobe arrived while busy, frame lost
   logic              sum_byte;   // current byte contributes to the checksum

   assign xfer = tx_valid & tx_ready;

   // Next-state, byte selection and latch/drop decisions.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
      state_next = state;
      idx_next   = idx;
      latch      = 1'b0;
      sum_byte   = 1'b0;
      tx_byte    = 8'h00;
      tx_valid   = (state != IDLE);
      busy       = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (frame_strobe) begin
               latch      = 1'b1;
               state_next = HEADER;
               idx_next   = '0;
            end
         end
         HEADER: begin
            if (idx == '0)           tx_byte = 8'hA5;
            else if (idx == IDX_W'(1)) tx_byte = 8'h5A;
            else if (idx == IDX_SEQ) tx_byte = seq;
            else                     tx_byte = drops;
            sum_byte = (idx >= IDX_SEQ);
            if (xfer) begin
               if (idx == LAST_HDR) begin
                  state_next = PAYLOAD;
                  idx_next   = '0;
               end else begin
                  idx_next = idx + IDX_W'(1);
               end
            end
         end
         PAYLOAD: begin
            // Word k sits at bit k*RESOLUTION, LSB first, so payload byte p is
            // simply byte p of the snapshot.
            tx_byte  = snapshot[8*int'(idx) +: 8];
            sum_byte = 1'b1;
            if (xfer) begin
               if (idx == LAST_PAY) begin
                  state_next = CHECK;
                  idx_next   = '0;
               end else begin
                  idx_next = idx + IDX_W'(1);
               end
            end
         end
         CHECK: begin
            tx_byte = csum;
            if (xfer) begin
               idx_next = '0;
               // A strobe on the final transfer chains straight into a new frame.
               if (frame_strobe) begin
                  latch      = 1'b1;
                  state_next = HEADER;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      drop = frame_strobe & (state != IDLE) & ~latch;
   end

   // State, counters, checksum and sticky overflow.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is written with non-blocking assignments only.
      if (reset) begin
         state    <= IDLE;
         idx      <= '0;
         seq      <= 8'h00;
         drop_cnt <= 8'h00;
         drops    <= 8'h00;
         csum     <= 8'h00;
         overflow <= 1'b0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
         if (state == CHECK && xfer) seq <= seq + 8'd1;
         if (latch) begin
            drops    <= drop_cnt;
            drop_cnt <= 8'h00;
            csum     <= 8'h00;
         end else begin
            if (drop) begin
               overflow <= 1'b1;
               if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
            if (xfer && sum_byte) csum <= csum + tx_byte;
         end
      end
   end

   // Frame snapshot, written only on latch.
   always_ff @(posedge clk) begin
      // NOTE: the snapshot is a data register with no reset; it is always rewritten before it is read.
      if (latch && !reset) snapshot <= frame_data;
   end

endmodule

// File: tb/tb_frame_packer.sv
// Directed bench for frame_packer with NUM_WORDS=2, RESOLUTION=16.
module tb_frame_packer;

   typedef logic [7:0] frame_t [9];

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] frame_data = 32'h0;
   logic        frame_strobe = 1'b0;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        busy;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   frame_packer #(.NUM_WORDS(2), .RESOLUTION(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .frame_data   (frame_data),
      .frame_strobe (frame_strobe),
      .tx_byte      (tx_byte),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .busy         (busy),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic frame_t model_frame(input logic [7:0] s, input logic [7:0] d,
                                          input logic [31:0] data);
      frame_t     f;
      logic [7:0] sum;
      f[0] = 8'hA5;
      f[1] = 8'h5A;
      f[2] = s;
      f[3] = d;
      sum  = s + d;
      for (int i = 0; i < 4; i++) begin
         f[4+i] = data[8*i +: 8];
         sum    = sum + f[4+i];
      end
      f[8] = sum;
      return f;
   endfunction

   task automatic do_reset();
      reset        = 1'b1;
      frame_strobe = 1'b0;
      tx_ready     = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic start_frame(input logic [31:0] data);
      frame_data   = data;
      frame_strobe = 1'b1;
      @(negedge clk);
      frame_strobe = 1'b0;
   endtask

   // Consumes one frame starting at the current negedge. toggle: tx_ready
   // alternates 1,0; n_extra: strobes on loop cycles 1..n_extra; chain: strobe
   // on the CHECK transfer. frame_data is moved to next_data immediately so the
   // in-flight frame must not follow it.
   task automatic expect_frame(input string tag, input frame_t exp, input bit toggle,
                               input int n_extra, input bit chain,
                               input logic [31:0] next_data, output logic [7:0] seq_obs);
      int         n = 0;
      int         cyc = 0;
      bit         stall_prev = 1'b0;
      logic [7:0] held = 8'h00;
      seq_obs    = 8'hXX;
      frame_data = next_data;
      while (n < 9 && cyc < 100) begin
         if (stall_prev) check($sformatf("%s hold%0d", tag, n), {23'd0, tx_valid, tx_byte}, {23'd0, 1'b1, held});
         check($sformatf("%s valid%0d", tag, cyc), {31'd0, tx_valid}, 32'd1);
         check($sformatf("%s busy%0d", tag, cyc), {31'd0, busy}, 32'd1);
         tx_ready     = toggle ? (cyc % 2 == 0) : 1'b1;
         frame_strobe = (chain && n == 8 && tx_ready) || (cyc >= 1 && cyc <= n_extra);
         if (tx_valid && tx_ready) begin
            check($sformatf("%s byte%0d", tag, n), {24'd0, tx_byte}, {24'd0, exp[n]});
            if (n == 2) seq_obs = tx_byte;
            n++;
            stall_prev = 1'b0;
         end else begin
            stall_prev = tx_valid;
            held       = tx_byte;
         end
         @(negedge clk);
         cyc++;
      end
      frame_strobe = 1'b0;
      if (n < 9) check($sformatf("%s timeout", tag), n, 9);
   endtask

   initial begin
      frame_t     f;
      logic [7:0] s;
      frame_t     ref033;
      ref033 = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'hCD, 8'hAB, 8'h34, 8'h12, 8'hBE};

      @(negedge clk);
      do_reset();
      check("rst tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst tx_byte", {24'd0, tx_byte}, 32'h00);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst overflow", {31'd0, overflow}, 32'd0);

      // Basic frame at full rate.
      start_frame(32'h1234ABCD);
      expect_frame("f033", ref033, 1'b0, 0, 1'b0, 32'hDEADBEEF, s);
      check("f033 idle valid", {31'd0, tx_valid}, 32'd0);
      check("f033 idle busy", {31'd0, busy}, 32'd0);

      // Same frame with back-pressure.
      do_reset();
      start_frame(32'h1234ABCD);
      expect_frame("f034", ref033, 1'b1, 0, 1'b0, 32'h0BADF00D, s);
      check("f034 idle valid", {31'd0, tx_valid}, 32'd0);

      // Dropped strobes and the DROPS field.
      do_reset();
      start_frame(32'h1234ABCD);
      expect_frame("f035a", ref033, 1'b0, 3, 1'b0, 32'h55555555, s);
      check("f035 overflow", {31'd0, overflow}, 32'd1);
      start_frame(32'h00000000);
      f = '{8'hA5, 8'h5A, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04};
      expect_frame("f035b", f, 1'b0, 0, 1'b0, 32'h77777777, s);
      start_frame(32'hFFFFFFFF);
      f = '{8'hA5, 8'h5A, 8'h02, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE};
      expect_frame("f035c", f, 1'b0, 0, 1'b0, 32'h0, s);
      check("f035 overflow sticky", {31'd0, overflow}, 32'd1);

      // Strobe coincident with the CHECK transfer.
      start_frame(32'h01020304);
      expect_frame("f036a", model_frame(8'h03, 8'h00, 32'h01020304), 1'b0, 0, 1'b1, 32'h11223344, s);
      check("f036 chain byte", {24'd0, tx_byte}, 32'hA5);
      check("f036 chain valid", {31'd0, tx_valid}, 32'd1);
      check("f036 chain busy", {31'd0, busy}, 32'd1);
      expect_frame("f036b", model_frame(8'h04, 8'h00, 32'h11223344), 1'b0, 0, 1'b0, 32'h0, s);
      check("f036 idle valid", {31'd0, tx_valid}, 32'd0);

      // Reset in PAYLOAD, with a strobe in the same cycle.
      start_frame(32'hCAFEBABE);
      tx_ready = 1'b1;
      repeat (6) @(negedge clk);
      check("f038 mid busy", {31'd0, busy}, 32'd1);
      reset        = 1'b1;
      frame_strobe = 1'b1;
      @(negedge clk);
      reset        = 1'b0;
      frame_strobe = 1'b0;
      check("f038 rst valid", {31'd0, tx_valid}, 32'd0);
      check("f038 rst busy", {31'd0, busy}, 32'd0);
      check("f038 rst byte", {24'd0, tx_byte}, 32'h00);
      check("f038 rst overflow", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      check("f038 strobe ignored", {31'd0, busy}, 32'd0);
      start_frame(32'h89ABCDEF);
      expect_frame("f038b", model_frame(8'h00, 8'h00, 32'h89ABCDEF), 1'b0, 0, 1'b0, 32'h0, s);
      check("f038b seq", {24'd0, s}, 32'h00);

      // 257 chained frames: SEQ wraps.
      do_reset();
      start_frame(32'h0);
      for (int i = 0; i < 257; i++) begin
         logic [31:0] d_cur, d_nxt;
         d_cur = 32'h9E3779B9 * i;
         d_nxt = 32'h9E3779B9 * (i + 1);
         if (i == 0) d_cur = 32'h0;
         expect_frame($sformatf("f037_%0d", i), model_frame(8'(i), 8'h00, d_cur),
                      1'b0, 0, (i < 256), d_nxt, s);
         if (i == 255) check("f037 seq255", {24'd0, s}, 32'hFF);
         if (i == 256) check("f037 seq256", {24'd0, s}, 32'h00);
      end
      check("f037 idle valid", {31'd0, tx_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
